boot_seq_ctrl: RTL and testbench

BOOT_SEQ_CTRL -- requirements
Module: boot_seq_ctrl

---
 rtl/boot_seq_pkg.sv | 19 +
 rtl/boot_seq_sync.sv | 23 ++
 rtl/boot_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_boot_seq_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/boot_seq_pkg.sv
// rtl/boot_seq_pkg.sv - state encoding and default boot vectors for boot_seq_ctrl
package boot_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_STABLE     = 3'd1,
        ST_RELEASE    = 3'd2,
        ST_FETCH_WAIT = 3'd3,
        ST_RUN        = 3'd4
    } boot_state_t;

    localparam logic [31:0] DEFAULT_BOOT_ADDR_A = 32'h1A00_0000;
    localparam logic [31:0] DEFAULT_BOOT_ADDR_B = 32'h0000_0000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/boot_seq_sync.sv
// rtl/boot_seq_sync.sv - multi-flop synchroniser for a single asynchronous level
module boot_seq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d);
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/boot_seq_ctrl.sv
// rtl/boot_seq_ctrl.sv - PLL-lock gated staged reset release and core fetch enable
// Optional watchdog in RUN compiled in with BOOT_SEQ_WDT_EN.
module boot_seq_ctrl
    import boot_seq_pkg::*;
#(
    parameter int          NUM_DOMAINS        = 3,
    parameter int          LOCK_STABLE_CYCLES = 16,
    parameter int          STAGE_DELAY_CYCLES = 8,
    parameter logic [31:0] BOOT_ADDR_A        = DEFAULT_BOOT_ADDR_A,
    parameter logic [31:0] BOOT_ADDR_B        = DEFAULT_BOOT_ADDR_B,
    parameter int          WDT_CYCLES         = 65536
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   boot_sel,
    input  logic                   sw_reset_req,
    input  logic                   wdt_kick,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   fetch_enable,
    output logic [31:0]            boot_addr,
    output logic [2:0]             state_o,
    output logic                   lock_lost,
    output logic                   wdt_fired
);

    localparam int CNT_MAX = max2(LOCK_STABLE_CYCLES, STAGE_DELAY_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY_CYCLES - 1);

    boot_state_t             state;
    logic [CNT_W-1:0]        cnt;
    logic                    locked_s;
    logic [NUM_DOMAINS-1:0]  dom_next;

    boot_seq_sync #(.STAGES(2)) u_lock_sync (
        .clk   (clk_sys),
        .reset (reset),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Next release pattern: one more low-index domain out of reset.
    assign dom_next = (domain_rst_n << 1) | NUM_DOMAINS'(1);
    assign state_o  = state;

`ifdef BOOT_SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0] wdt_cnt;
`else
    logic unused_wdt;
    assign unused_wdt = wdt_kick ^ WDT_CYCLES[0];
    assign wdt_fired  = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            domain_rst_n <= '0;
            fetch_enable <= 1'b0;
            boot_addr    <= BOOT_ADDR_A;
            lock_lost    <= 1'b0;
`ifdef BOOT_SEQ_WDT_EN
            wdt_cnt      <= '0;
            wdt_fired    <= 1'b0;
`endif
        end else begin
`ifdef BOOT_SEQ_WDT_EN
            wdt_cnt <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (locked_s) state <= ST_STABLE;
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state     <= ST_RELEASE;
                        cnt       <= '0;
                        boot_addr <= boot_sel ? BOOT_ADDR_B : BOOT_ADDR_A;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE, ST_FETCH_WAIT: begin
                    if (!locked_s) begin
                        state        <= ST_IDLE;
                        cnt          <= '0;
                        domain_rst_n <= '0;
                        fetch_enable <= 1'b0;
                        lock_lost    <= 1'b1;
                    end else if (cnt != STAGE_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (state == ST_RELEASE) begin
                        cnt          <= '0;
                        domain_rst_n <= dom_next;
                        if (&dom_next) state <= ST_FETCH_WAIT;
                    end else begin
                        cnt          <= '0;
                        state        <= ST_RUN;
                        fetch_enable <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Lock loss takes priority over a coincident software request.
                    if (!locked_s) begin
                        state        <= ST_IDLE;
                        domain_rst_n <= '0;
                        fetch_enable <= 1'b0;
                        lock_lost    <= 1'b1;
                    end else if (sw_reset_req) begin
                        state        <= ST_IDLE;
                        domain_rst_n <= '0;
                        fetch_enable <= 1'b0;
                    end
`ifdef BOOT_SEQ_WDT_EN
                    else if (!wdt_kick && wdt_cnt == WDT_LAST) begin
                        state        <= ST_IDLE;
                        domain_rst_n <= '0;
                        fetch_enable <= 1'b0;
                        wdt_fired    <= 1'b1;
                    end else if (!wdt_kick) begin
                        wdt_cnt <= wdt_cnt + WDT_W'(1);
                    end
`endif
                end
                default: begin
                    state        <= ST_IDLE;
                    cnt          <= '0;
                    domain_rst_n <= '0;
                    fetch_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// tb/tb_boot_seq_ctrl.sv - directed self-checking bench for boot_seq_ctrl
module tb_boot_seq_ctrl;

    localparam logic [2:0]  S_IDLE = 3'd0, S_STABLE = 3'd1, S_RELEASE = 3'd2,
                            S_FW = 3'd3, S_RUN = 3'd4;
    localparam logic [31:0] ADDR_A = 32'h1A00_0000;
    localparam logic [31:0] ADDR_B = 32'h0000_0000;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        pll_locked = 1'b0;
    logic        boot_sel = 1'b0;
    logic        sw_reset_req = 1'b0;
    logic        wdt_kick = 1'b0;
    logic [2:0]  domain_rst_n;
    logic        fetch_enable;
    logic [31:0] boot_addr;
    logic [2:0]  state_o;
    logic        lock_lost;
    logic        wdt_fired;

    int checks = 0;
    int errors = 0;

    boot_seq_ctrl #(
        .NUM_DOMAINS(3), .LOCK_STABLE_CYCLES(8), .STAGE_DELAY_CYCLES(4), .WDT_CYCLES(32)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .pll_locked(pll_locked), .boot_sel(boot_sel),
        .sw_reset_req(sw_reset_req), .wdt_kick(wdt_kick), .domain_rst_n(domain_rst_n),
        .fetch_enable(fetch_enable), .boot_addr(boot_addr), .state_o(state_o),
        .lock_lost(lock_lost), .wdt_fired(wdt_fired)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          cyc;
        logic [2:0]  st;
        logic [2:0]  dom;
        logic        fe;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output int n);
        n = 0;
        while (state_o !== target && n < budget) begin
            step();
            n++;
        end
        check("wait_state_reached", {29'd0, state_o}, {29'd0, target});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, {29'd0, state_o}, {29'd0, S_IDLE});
        check({tag, "_dom"}, {29'd0, domain_rst_n}, 32'd0);
        check({tag, "_fe"}, {31'd0, fetch_enable}, 32'd0);
        check({tag, "_addr"}, boot_addr, ADDR_A);
        check({tag, "_lock_lost"}, {31'd0, lock_lost}, 32'd0);
        check({tag, "_wdt_fired"}, {31'd0, wdt_fired}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int vi;
        vecs[0]  = '{1,  S_IDLE,    3'b000, 1'b0, ADDR_A};
        vecs[1]  = '{2,  S_STABLE,  3'b000, 1'b0, ADDR_A};
        vecs[2]  = '{9,  S_STABLE,  3'b000, 1'b0, ADDR_A};
        vecs[3]  = '{10, S_RELEASE, 3'b000, 1'b0, ADDR_B};
        vecs[4]  = '{13, S_RELEASE, 3'b000, 1'b0, ADDR_B};
        vecs[5]  = '{14, S_RELEASE, 3'b001, 1'b0, ADDR_B};
        vecs[6]  = '{17, S_RELEASE, 3'b001, 1'b0, ADDR_B};
        vecs[7]  = '{18, S_RELEASE, 3'b011, 1'b0, ADDR_B};
        vecs[8]  = '{21, S_RELEASE, 3'b011, 1'b0, ADDR_B};
        vecs[9]  = '{22, S_FW,      3'b111, 1'b0, ADDR_B};
        vecs[10] = '{25, S_FW,      3'b111, 1'b0, ADDR_B};
        vecs[11] = '{26, S_RUN,     3'b111, 1'b1, ADDR_B};

        step();
        step();
        check_reset_values("reset");
        reset = 1'b0;

        // Nominal boot: first edge seeing pll_locked=1 is cycle 0.
        boot_sel   = 1'b1;
        pll_locked = 1'b1;
        vi = 0;
        for (int c = 0; c <= 26; c++) begin
            step();
            if (vi < 12 && vecs[vi].cyc == c) begin
                check($sformatf("nom%0d_state", c), {29'd0, state_o}, {29'd0, vecs[vi].st});
                check($sformatf("nom%0d_dom", c), {29'd0, domain_rst_n}, {29'd0, vecs[vi].dom});
                check($sformatf("nom%0d_fe", c), {31'd0, fetch_enable}, {31'd0, vecs[vi].fe});
                check($sformatf("nom%0d_addr", c), boot_addr, vecs[vi].addr);
                check($sformatf("nom%0d_lock_lost", c), {31'd0, lock_lost}, 32'd0);
                vi++;
            end
        end

        // boot_sel changes outside the latch edge leave boot_addr alone.
        boot_sel = 1'b0;
        step(); step(); step();
        check("bootsel_hold_addr", boot_addr, ADDR_B);

        // Software reset in RUN.
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("swrst_state", {29'd0, state_o}, {29'd0, S_IDLE});
        check("swrst_dom", {29'd0, domain_rst_n}, 32'd0);
        check("swrst_fe", {31'd0, fetch_enable}, 32'd0);
        check("swrst_lock_lost", {31'd0, lock_lost}, 32'd0);

        // Reboot with boot_sel=0; sw_reset_req in RELEASE must not disturb timing.
        wait_state(S_RELEASE, 40, n);
        check("reboot_addr_a", boot_addr, ADDR_A);
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("swrst_in_release_state", {29'd0, state_o}, {29'd0, S_RELEASE});
        wait_state(S_RUN, 40, n);
        check("release_to_run_cycles", n + 1, 16);

        // Lock loss in RUN: two synchroniser edges, then FSM reacts.
        pll_locked = 1'b0;
        step(); step();
        check("lockloss_pre_state", {29'd0, state_o}, {29'd0, S_RUN});
        check("lockloss_pre_fe", {31'd0, fetch_enable}, 32'd1);
        step();
        check("lockloss_state", {29'd0, state_o}, {29'd0, S_IDLE});
        check("lockloss_dom", {29'd0, domain_rst_n}, 32'd0);
        check("lockloss_fe", {31'd0, fetch_enable}, 32'd0);
        check("lockloss_flag", {31'd0, lock_lost}, 32'd1);
        pll_locked = 1'b1;
        wait_state(S_RUN, 60, n);
        check("relock_lock_lost_sticky", {31'd0, lock_lost}, 32'd1);
        check("relock_fe", {31'd0, fetch_enable}, 32'd1);

        // Reset clears sticky flag; then a one-cycle lock glitch at STABLE count 5.
        reset = 1'b1;
        pll_locked = 1'b0;
        step(); step();
        check_reset_values("reset2");
        reset = 1'b0;
        boot_sel = 1'b1;
        for (int c = 0; c <= 17; c++) begin
            pll_locked = (c == 6) ? 1'b0 : 1'b1;
            step();
            if (c == 7)  check("glitch_c7_state", {29'd0, state_o}, {29'd0, S_STABLE});
            if (c == 8)  check("glitch_c8_state", {29'd0, state_o}, {29'd0, S_IDLE});
            if (c == 8)  check("glitch_c8_lock_lost", {31'd0, lock_lost}, 32'd0);
            if (c == 9)  check("glitch_c9_state", {29'd0, state_o}, {29'd0, S_STABLE});
            if (c == 16) check("glitch_c16_state", {29'd0, state_o}, {29'd0, S_STABLE});
            if (c == 17) check("glitch_c17_state", {29'd0, state_o}, {29'd0, S_RELEASE});
        end

        // Reset while in FETCH_WAIT.
        wait_state(S_FW, 40, n);
        check("fw_addr_before_reset", boot_addr, ADDR_B);
        reset = 1'b1;
        step();
        check_reset_values("reset_fw");
        reset = 1'b0;

`ifdef BOOT_SEQ_WDT_EN
        wait_state(S_RUN, 80, n);
        for (int i = 0; i < 31; i++) step();
        check("wdt_31_state", {29'd0, state_o}, {29'd0, S_RUN});
        check("wdt_31_fired", {31'd0, wdt_fired}, 32'd0);
        step();
        check("wdt_32_state", {29'd0, state_o}, {29'd0, S_IDLE});
        check("wdt_32_fired", {31'd0, wdt_fired}, 32'd1);
        check("wdt_32_dom", {29'd0, domain_rst_n}, 32'd0);
        check("wdt_32_fe", {31'd0, fetch_enable}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_state(S_RUN, 80, n);
        for (int i = 0; i < 100; i++) begin
            wdt_kick = (i % 20 == 19);
            step();
        end
        wdt_kick = 1'b0;
        check("wdt_kicked_state", {29'd0, state_o}, {29'd0, S_RUN});
        check("wdt_kicked_fired", {31'd0, wdt_fired}, 32'd0);
`else
        wait_state(S_RUN, 80, n);
        for (int i = 0; i < 40; i++) step();
        check("nowdt_state", {29'd0, state_o}, {29'd0, S_RUN});
        check("nowdt_fired", {31'd0, wdt_fired}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
